// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops plus an
// iterative 1-bit-per-cycle shifter with a start/ready/done handshake.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [3:0]         ALU_control,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     acc_reg, acc_next;
    logic [SHAMT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]           op_reg, op_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic                 zero_reg, zero_next;
    logic                 done_reg, done_next;

    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic [WIDTH-1:0]     alu_value;
    logic [WIDTH-1:0]     acc_shifted;

    assign shamt    = B[SHAMT_W-1:0];
    assign is_shift = (ALU_control == OP_SRA) || (ALU_control == OP_SLL) ||
                      (ALU_control == OP_SRL);

    // Single-cycle datapath; a shift reaching here has shamt 0 and passes A through.
    always_comb begin
        alu_value = '0;
        case (ALU_control)
            OP_ADD:  alu_value = A + B;
            OP_SUB:  alu_value = A - B;
            OP_AND:  alu_value = A & B;
            OP_OR:   alu_value = A | B;
            OP_XOR:  alu_value = A ^ B;
            OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_value = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SRA,
            OP_SLL,
            OP_SRL:  alu_value = A;
            default: alu_value = '0;
        endcase
    end

    // One-bit shift step of the accumulator using the latched opcode.
    always_comb begin
        acc_shifted = acc_reg;
        case (op_reg)
            OP_SLL:  acc_shifted = {acc_reg[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc_reg[WIDTH-1:1]};
            default: acc_shifted = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
        endcase
    end

    // Next-state and registered-output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_next   = A;
                        cnt_next   = shamt;
                        op_next    = ALU_control;
                        state_next = SHIFT;
                    end else begin
                        result_next = alu_value;
                        zero_next   = (alu_value == '0);
                        done_next   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_next = acc_shifted;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == SHAMT_W'(1)) begin
                    result_next = acc_shifted;
                    zero_next   = (acc_shifted == '0);
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            done_reg   <= done_next;
        end
    end

    assign ready  = (state_reg == IDLE);
    assign done   = done_reg;
    assign result = result_reg;
    assign zero   = zero_reg;

endmodule
